// File: rtl/ex_stage.sv
// RV32IM execute stage: ID/EX operand latch, single-cycle ALU with branch/jump
// resolution, and a 1-bit/cycle iterative MUL/DIV unit (IDLE -> RUN -> DONE).
// Result, memory and writeback outputs are combinational from the latched operands.
module ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int MD_CYC = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [4:0]        id_op,
    input  logic [DATA_W-1:0] id_rs1_data,
    input  logic [DATA_W-1:0] id_rs2_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_use_imm,
    input  logic [REG_W-1:0]  id_rd,
    output logic              ex_valid,
    output logic              ex_mem_ena,
    output logic              mem_rw_o,
    output logic [DATA_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [REG_W-1:0]  gprs_waddr_o,
    output logic [DATA_W-1:0] gprs_wdata_o,
    output logic              ex_busy,
    output logic              jump_flag,
    output logic [DATA_W-1:0] jump_addr
);
    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;
    localparam int   CW        = $clog2(MD_CYC);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} md_state_e;

    md_state_e         state_q;
    logic [CW-1:0]     cnt_q;
    logic [DATA_W-1:0] a_q, b_q, acc_q;
    logic [DATA_W-1:0] a_d, b_d, acc_d;

    logic              v_q, use_imm_q;
    logic [4:0]        op_q;
    logic [DATA_W-1:0] pc_q, rs1_q, rs2_q, imm_q;
    logic [REG_W-1:0]  rd_q;

    function automatic logic is_md(input logic [4:0] op);
        return (op >= 5'd22) && (op <= 5'd26);
    endfunction

    // MUL, DIV and REM work on magnitudes and get their sign fixed up in DONE
    function automatic logic is_sgn(input logic [4:0] op);
        return (op == 5'd22) || (op == 5'd23) || (op == 5'd25);
    endfunction

    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic sgn);
        return (sgn && v[DATA_W-1]) ? (~v + 1'b1) : v;
    endfunction

    assign ex_busy = (state_q == S_RUN);

    // A new M-op can start from IDLE or on the edge that retires the previous DONE
    logic md_start;
    assign md_start = !stall_i && id_valid && is_md(id_op) &&
                      (state_q == S_IDLE || state_q == S_DONE);

    // ID/EX latch: rst > flush > hold (stall or mul/div running) > load
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= 1'b0; op_q <= '0; pc_q <= '0; rs1_q <= '0; rs2_q <= '0;
            imm_q <= '0; use_imm_q <= 1'b0; rd_q <= '0;
        end else if (flush_i) begin
            v_q <= 1'b0;
        end else if (!(stall_i || ex_busy)) begin
            v_q <= id_valid; op_q <= id_op; pc_q <= id_pc; rs1_q <= id_rs1_data;
            rs2_q <= id_rs2_data; imm_q <= id_imm; use_imm_q <= id_use_imm; rd_q <= id_rd;
        end
    end

    // One iteration: shift-add multiply, or restoring shift-subtract divide
    // (a_q shifts out dividend bits and collects quotient bits, acc_q is the remainder)
    logic [DATA_W:0] rtry, rdiff;
    always_comb begin
        a_d = a_q; b_d = b_q; acc_d = acc_q;
        rtry  = {acc_q, a_q[DATA_W-1]};
        rdiff = rtry - {1'b0, b_q};
        if (op_q == 5'd22) begin
            acc_d = acc_q + (b_q[0] ? a_q : '0);
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
        end else if (!rdiff[DATA_W]) begin
            acc_d = rdiff[DATA_W-1:0];
            a_d   = {a_q[DATA_W-2:0], 1'b1};
        end else begin
            acc_d = rtry[DATA_W-1:0];
            a_d   = {a_q[DATA_W-2:0], 1'b0};
        end
    end

    // Mul/div sequencer; DONE holds through stall so the result is not lost
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE; cnt_q <= '0; a_q <= '0; b_q <= '0; acc_q <= '0;
        end else if (flush_i) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_RUN: begin
                    a_q <= a_d; b_q <= b_d; acc_q <= acc_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) state_q <= S_DONE;
                end
                default: begin
                    if (md_start) begin
                        state_q <= S_RUN;
                        cnt_q   <= CW'(MD_CYC - 1);
                        a_q     <= mag(id_rs1_data, is_sgn(id_op));
                        b_q     <= mag(id_rs2_data, is_sgn(id_op));
                        acc_q   <= '0;
                    end else if (state_q == S_DONE && !stall_i) begin
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Sign fixup and divide-by-zero results for the finished M-op
    logic [DATA_W-1:0] md_res;
    logic              neg;
    always_comb begin
        neg    = rs1_q[DATA_W-1] ^ rs2_q[DATA_W-1];
        md_res = '0;
        case (op_q)
            5'd22:   md_res = neg ? (~acc_q + 1'b1) : acc_q;
            5'd23:   md_res = (rs2_q == '0) ? '1 : (neg ? (~a_q + 1'b1) : a_q);
            5'd24:   md_res = (rs2_q == '0) ? '1 : a_q;
            5'd25:   md_res = (rs2_q == '0) ? rs1_q :
                              (rs1_q[DATA_W-1] ? (~acc_q + 1'b1) : acc_q);
            5'd26:   md_res = (rs2_q == '0) ? rs1_q : acc_q;
            default: md_res = '0;
        endcase
    end

    // Single-cycle execute and output drive; everything is zero unless ex_valid
    logic [DATA_W-1:0] opb;
    logic              taken;
    always_comb begin
        opb          = use_imm_q ? imm_q : rs2_q;
        ex_valid     = (state_q == S_DONE) || (state_q == S_IDLE && v_q && !is_md(op_q));
        ex_mem_ena   = 1'b0;
        mem_rw_o     = MEM_READ;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        gprs_waddr_o = '0;
        gprs_wdata_o = '0;
        taken        = 1'b0;
        jump_addr    = '0;
        if (ex_valid) begin
            gprs_waddr_o = rd_q;
            case (op_q)
                5'd0:  gprs_wdata_o = rs1_q + opb;
                5'd1:  gprs_wdata_o = rs1_q - rs2_q;
                5'd2:  gprs_wdata_o = rs1_q << opb[4:0];
                5'd3:  gprs_wdata_o = {{(DATA_W-1){1'b0}}, $signed(rs1_q) < $signed(opb)};
                5'd4:  gprs_wdata_o = {{(DATA_W-1){1'b0}}, rs1_q < opb};
                5'd5:  gprs_wdata_o = rs1_q ^ opb;
                5'd6:  gprs_wdata_o = rs1_q >> opb[4:0];
                5'd7:  gprs_wdata_o = $signed(rs1_q) >>> opb[4:0];
                5'd8:  gprs_wdata_o = rs1_q | opb;
                5'd9:  gprs_wdata_o = rs1_q & opb;
                5'd10: gprs_wdata_o = imm_q;
                5'd11: gprs_wdata_o = pc_q + imm_q;
                5'd12: begin
                    gprs_wdata_o = pc_q + 32'd4; taken = 1'b1; jump_addr = pc_q + imm_q;
                end
                5'd13: begin
                    gprs_wdata_o = pc_q + 32'd4; taken = 1'b1;
                    jump_addr = (rs1_q + imm_q) & ~32'd1;
                end
                5'd14, 5'd15, 5'd16, 5'd17, 5'd18, 5'd19: begin
                    gprs_waddr_o = '0;
                    case (op_q)
                        5'd14:   taken = (rs1_q == rs2_q);
                        5'd15:   taken = (rs1_q != rs2_q);
                        5'd16:   taken = ($signed(rs1_q) < $signed(rs2_q));
                        5'd17:   taken = ($signed(rs1_q) >= $signed(rs2_q));
                        5'd18:   taken = (rs1_q < rs2_q);
                        default: taken = (rs1_q >= rs2_q);
                    endcase
                    if (taken) jump_addr = pc_q + imm_q;
                end
                5'd20: begin
                    ex_mem_ena = 1'b1; mem_rw_o = MEM_READ; mem_addr_o = rs1_q + imm_q;
                end
                5'd21: begin
                    ex_mem_ena = 1'b1; mem_rw_o = MEM_WRITE; mem_addr_o = rs1_q + imm_q;
                    mem_wdata_o = rs2_q; gprs_waddr_o = '0;
                end
                5'd22, 5'd23, 5'd24, 5'd25, 5'd26: gprs_wdata_o = md_res;
                default: gprs_waddr_o = '0;
            endcase
        end
        jump_flag = ex_valid & taken;
    end
endmodule

// File: tb/tb_ex_stage.sv
// Directed-vector bench for ex_stage with hand-computed expectations.
module tb_ex_stage;
    logic        clk = 1'b0;
    logic        rst, stall_i, flush_i, id_valid, id_use_imm;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_op, id_rd;
    logic        ex_valid, ex_mem_ena, mem_rw_o, ex_busy, jump_flag;
    logic [31:0] mem_addr_o, mem_wdata_o, gprs_wdata_o, jump_addr;
    logic [4:0]  gprs_waddr_o;

    int n_chk = 0;
    int n_ok  = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .id_valid(id_valid), .id_pc(id_pc), .id_op(id_op),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_use_imm(id_use_imm), .id_rd(id_rd),
        .ex_valid(ex_valid), .ex_mem_ena(ex_mem_ena), .mem_rw_o(mem_rw_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .gprs_waddr_o(gprs_waddr_o), .gprs_wdata_o(gprs_wdata_o),
        .ex_busy(ex_busy), .jump_flag(jump_flag), .jump_addr(jump_addr)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_ok++;
        else $display("FAIL %s: got %h want %h", tag, act, exp);
    endtask

    // present one instruction for a single latch edge, then drop id_valid
    task automatic issue(input logic [4:0] op, input logic [31:0] pc, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] imm, input logic ui,
                         input logic [4:0] rd);
        @(negedge clk);
        id_op = op; id_pc = pc; id_rs1_data = r1; id_rs2_data = r2;
        id_imm = imm; id_use_imm = ui; id_rd = rd; id_valid = 1'b1;
        @(posedge clk);
        #1 id_valid = 1'b0;
    endtask

    // count busy cycles; leaves the caller at the first non-busy negedge
    task automatic wait_busy(output int cyc);
        cyc = 0;
        @(negedge clk);
        while (ex_busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic run_md(input string tag, input logic [4:0] op, input logic [31:0] r1,
                          input logic [31:0] r2, input logic [4:0] rd, input logic [31:0] exp);
        int cyc;
        issue(op, 32'h0, r1, r2, 32'h0, 1'b0, rd);
        wait_busy(cyc);
        chk({tag, "_busy"}, cyc, 32);
        chk({tag, "_vld"}, {31'b0, ex_valid}, 1);
        chk({tag, "_wa"}, {27'b0, gprs_waddr_o}, {27'b0, rd});
        chk(tag, gprs_wdata_o, exp);
        @(negedge clk);
        chk({tag, "_once"}, {31'b0, ex_valid}, 0);
    endtask

    initial begin
        int cyc, seen;
        rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; id_valid = 1'b0; id_use_imm = 1'b0;
        id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0; id_op = '0; id_rd = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_vld", {31'b0, ex_valid}, 0);
        chk("rst_busy", {31'b0, ex_busy}, 0);
        chk("rst_wa", {27'b0, gprs_waddr_o}, 0);
        chk("rst_jmp", {31'b0, jump_flag}, 0);

        issue(5'd0, 32'h0, 32'd5, 32'd7, 32'h0, 1'b0, 5'd3);
        @(negedge clk);
        chk("add_vld", {31'b0, ex_valid}, 1);
        chk("add_wa", {27'b0, gprs_waddr_o}, 3);
        chk("add_wd", gprs_wdata_o, 12);
        chk("add_jmp", {31'b0, jump_flag}, 0);

        issue(5'd1, 32'h0, 32'd5, 32'd7, 32'd100, 1'b1, 5'd1);
        @(negedge clk);
        chk("sub_rs2", gprs_wdata_o, 32'hFFFF_FFFE);

        issue(5'd7, 32'h0, 32'h8000_0010, 32'd0, 32'd4, 1'b1, 5'd2);
        @(negedge clk);
        chk("sra_imm", gprs_wdata_o, 32'hF800_0001);

        issue(5'd3, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0, 5'd2);
        @(negedge clk);
        chk("slt", gprs_wdata_o, 1);

        issue(5'd16, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b0, 5'd7);
        @(negedge clk);
        chk("blt_t_flag", {31'b0, jump_flag}, 1);
        chk("blt_t_addr", jump_addr, 32'h120);
        chk("blt_t_wa", {27'b0, gprs_waddr_o}, 0);

        issue(5'd16, 32'h100, 32'd2, 32'd1, 32'h20, 1'b0, 5'd7);
        @(negedge clk);
        chk("blt_n_flag", {31'b0, jump_flag}, 0);
        chk("blt_n_addr", jump_addr, 0);

        issue(5'd13, 32'h200, 32'h301, 32'd0, 32'h10, 1'b0, 5'd1);
        @(negedge clk);
        chk("jalr_flag", {31'b0, jump_flag}, 1);
        chk("jalr_addr", jump_addr, 32'h310);
        chk("jalr_wd", gprs_wdata_o, 32'h204);

        issue(5'd20, 32'h0, 32'h1000, 32'h55, 32'hFFFF_FFFC, 1'b0, 5'd6);
        @(negedge clk);
        chk("ld_ena", {31'b0, ex_mem_ena}, 1);
        chk("ld_rw", {31'b0, mem_rw_o}, 0);
        chk("ld_addr", mem_addr_o, 32'hFFC);
        chk("ld_wa", {27'b0, gprs_waddr_o}, 6);
        chk("ld_wd", gprs_wdata_o, 0);

        issue(5'd21, 32'h0, 32'h1000, 32'hCAFE, 32'h8, 1'b0, 5'd6);
        @(negedge clk);
        chk("st_rw", {31'b0, mem_rw_o}, 1);
        chk("st_wa", {27'b0, gprs_waddr_o}, 0);
        chk("st_wdata", mem_wdata_o, 32'hCAFE);

        run_md("divu", 5'd24, 32'd100, 32'd7, 5'd4, 32'd14);
        run_md("remu", 5'd26, 32'd100, 32'd7, 5'd4, 32'd2);
        run_md("div0", 5'd23, 32'd5, 32'd0, 5'd5, 32'hFFFF_FFFF);
        run_md("rem0", 5'd25, 32'hFFFF_FFF9, 32'd0, 5'd5, 32'hFFFF_FFF9);
        run_md("divovf", 5'd23, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 32'h8000_0000);
        run_md("removf", 5'd25, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 32'h0);
        run_md("remneg", 5'd25, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFF);
        run_md("divneg", 5'd23, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD);
        run_md("mul", 5'd22, 32'hFFFF_FFFD, 32'd5, 5'd8, 32'hFFFF_FFF1);

        // flush mid-RUN: back to IDLE, the result never appears
        issue(5'd24, 32'h0, 32'd100, 32'd7, 32'h0, 1'b0, 5'd4);
        repeat (10) @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk);
        #1 flush_i = 1'b0;
        @(negedge clk);
        chk("flush_busy", {31'b0, ex_busy}, 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (ex_valid) seen++;
            @(negedge clk);
        end
        chk("flush_novld", seen, 0);

        // stall through DONE: result held, queued ADD latched on release
        issue(5'd22, 32'h0, 32'd6, 32'd7, 32'h0, 1'b0, 5'd9);
        repeat (5) @(negedge clk);
        stall_i = 1'b1;
        wait_busy(cyc);
        chk("stl_busy", cyc, 27);
        id_op = 5'd0; id_rs1_data = 32'd1; id_rs2_data = 32'd2; id_use_imm = 1'b0;
        id_rd = 5'd10; id_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("stl_vld", {31'b0, ex_valid}, 1);
            chk("stl_wd", gprs_wdata_o, 42);
            if (i < 2) @(negedge clk);
        end
        stall_i = 1'b0;
        @(posedge clk);
        #1 id_valid = 1'b0;
        @(negedge clk);
        chk("stl_next_wa", {27'b0, gprs_waddr_o}, 10);
        chk("stl_next_wd", gprs_wdata_o, 3);

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end
endmodule
